// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and width helpers for the FIFO and the UART datapath blocks.
//   FIFO_MODE_STD  : registered read, rd_data valid one cycle after the pop
//   FIFO_MODE_FWFT : head word is shown combinationally while not empty
//   fifo_aw(depth) : storage address width
//   fifo_cw(depth) : pointer/count width (one extra bit to tell full from empty)
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int fifo_aw(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int fifo_cw(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write word
//   raddr : read address
//   rdata : word at raddr (combinational)
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = fifo_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable standard / FWFT read mode.
// Storage lives in fifo_mem; this module owns pointers, count, flags and the
// read output register.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   flush        : synchronous clear of pointers, count and error flags
//   wr_en/wr_data: write request and word
//   rd_en        : pop request
//   rd_data      : read word (registered in standard mode, head word in FWFT)
//   rd_valid     : standard: pulse when rd_data updated; FWFT: !empty
//   full/empty/almost_full/almost_empty : decodes of count
//   count        : occupancy 0..DEPTH
//   overflow     : sticky, a write was rejected
//   underflow    : sticky, a read was rejected
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int FWFT     = FIFO_MODE_STD,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   rd_valid,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int CW = fifo_cw(DEPTH);
   localparam int AW = fifo_aw(DEPTH);

   logic [CW-1:0]    wptr;
   logic [CW-1:0]    rptr;
   logic [CW-1:0]    count_q;
   logic             overflow_q;
   logic             underflow_q;
   logic             rd_acc;
   logic             wr_acc;
   logic [WIDTH-1:0] mem_rdata;

   assign empty        = (count_q == '0);
   assign full         = (count_q == CW'(DEPTH));
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A read on a full FIFO frees the slot in the same cycle, so the write
   // may proceed. No bypass on empty: the read is rejected instead.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr        <= '0;
         rptr        <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (flush) begin
         wptr        <= '0;
         rptr        <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_acc) begin
            rptr <= rptr + 1'b1;
         end
         count_q <= count_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
         if (wr_en && !wr_acc) begin
            overflow_q <= 1'b1;
         end
         if (rd_en && !rd_acc) begin
            underflow_q <= 1'b1;
         end
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wptr[AW-1:0]),
      .wdata (wr_data),
      .raddr (rptr[AW-1:0]),
      .rdata (mem_rdata)
   );

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         assign rd_data  = mem_rdata;
         assign rd_valid = !empty;
      end else begin : g_std
         logic [WIDTH-1:0] rd_data_q;
         logic             rd_valid_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else if (flush) begin
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_acc;
               if (rd_acc) begin
                  rd_data_q <= mem_rdata;
               end
            end
         end

         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

   // Pointer-derived full/empty must agree with the count decodes.
   ptr_count_agree : assert property (@(posedge clk) disable iff (!rst_n)
      ((wptr == rptr) == empty) &&
      (((wptr[CW-1] != rptr[CW-1]) && (wptr[AW-1:0] == rptr[AW-1:0])) == full));

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

   typedef struct {
      logic       flush;
      logic       wr;
      logic [7:0] wd;
      logic       rd;
      int         cnt;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       ovf;
      logic       unf;
      logic       rv;
      logic       chk;
      logic [7:0] rdd;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       s_flush = 0, s_wr = 0, s_rd = 0;
   logic [7:0] s_wd = '0;
   logic [7:0] s_rdd;
   logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic [4:0] s_cnt;

   logic       f_flush = 0, f_wr = 0, f_rd = 0;
   logic [7:0] f_wd = '0;
   logic [7:0] f_rdd;
   logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [4:0] f_cnt;

   int n_pass = 0;
   int n_total = 0;

   vec_t vecs[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .flush(s_flush), .wr_en(s_wr), .wr_data(s_wd),
      .rd_en(s_rd), .rd_data(s_rdd), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
      .overflow(s_ovf), .underflow(s_unf)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr), .wr_data(f_wd),
      .rd_en(f_rd), .rd_data(f_rdd), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
      .overflow(f_ovf), .underflow(f_unf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic vec_t mk(input logic fl, input logic wr, input logic [7:0] wd,
                               input logic rd, input int cnt, input logic ovf,
                               input logic unf, input logic rv, input logic chk,
                               input logic [7:0] rdd);
      vec_t v;
      v.flush = fl; v.wr = wr; v.wd = wd; v.rd = rd; v.cnt = cnt;
      v.full  = (cnt == 16);
      v.empty = (cnt == 0);
      v.af    = (cnt >= 14);
      v.ae    = (cnt <= 2);
      v.ovf = ovf; v.unf = unf; v.rv = rv; v.chk = chk; v.rdd = rdd;
      return v;
   endfunction

   // Drive standard-mode inputs at negedge, sample 1 ns after the next posedge.
   task automatic step_std(input logic fl, input logic wr, input logic [7:0] wd, input logic rd);
      @(negedge clk);
      s_flush = fl; s_wr = wr; s_wd = wd; s_rd = rd;
      @(posedge clk);
      #1;
      s_flush = 0; s_wr = 0; s_rd = 0;
   endtask

   task automatic step_fwft(input logic fl, input logic wr, input logic [7:0] wd, input logic rd);
      @(negedge clk);
      f_flush = fl; f_wr = wr; f_wd = wd; f_rd = rd;
      @(posedge clk);
      #1;
      f_flush = 0; f_wr = 0; f_rd = 0;
   endtask

   task automatic check_std(input string tag, input vec_t v);
      check({tag, " count"}, 32'(s_cnt), 32'(v.cnt));
      check({tag, " full"}, 32'(s_full), 32'(v.full));
      check({tag, " empty"}, 32'(s_empty), 32'(v.empty));
      check({tag, " almost_full"}, 32'(s_af), 32'(v.af));
      check({tag, " almost_empty"}, 32'(s_ae), 32'(v.ae));
      check({tag, " overflow"}, 32'(s_ovf), 32'(v.ovf));
      check({tag, " underflow"}, 32'(s_unf), 32'(v.unf));
      check({tag, " rd_valid"}, 32'(s_rv), 32'(v.rv));
      if (v.chk) check({tag, " rd_data"}, 32'(s_rdd), 32'(v.rdd));
   endtask

   initial begin
      // Fill 0x11..0x20, reject 0x21, drain 16, then one rejected read.
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(0, 1, 8'(8'h11 + i), 0, i + 1, 0, 0, 0, 0, 8'h00));
      vecs.push_back(mk(0, 1, 8'h21, 0, 16, 1, 0, 0, 0, 8'h00));
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(0, 0, 8'h00, 1, 15 - i, 1, 0, 1, 1, 8'(8'h11 + i)));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 0, 1, 8'h20));
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));

      #12;
      check("reset std count", 32'(s_cnt), 0);
      check("reset std empty", 32'(s_empty), 1);
      check("reset std full", 32'(s_full), 0);
      check("reset std almost_empty", 32'(s_ae), 1);
      check("reset std almost_full", 32'(s_af), 0);
      check("reset std rd_valid", 32'(s_rv), 0);
      check("reset std rd_data", 32'(s_rdd), 0);
      check("reset std flags", {30'd0, s_ovf, s_unf}, 0);
      check("reset fwft rd_valid", 32'(f_rv), 0);
      check("reset fwft empty", 32'(f_empty), 1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step_std(vecs[i].flush, vecs[i].wr, vecs[i].wd, vecs[i].rd);
         check_std($sformatf("vec%0d", i), vecs[i]);
      end

      // Full FIFO with simultaneous read and write across pointer wrap.
      for (int i = 0; i < 16; i++) begin
         step_std(0, 1, 8'(8'h40 + i), 0);
         exp_q.push_back(8'(8'h40 + i));
      end
      check("fill2 full", 32'(s_full), 1);
      for (int k = 0; k < 20; k++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         exp_q.push_back(8'(8'h60 + k));
         step_std(0, 1, 8'(8'h60 + k), 1);
         check($sformatf("rw%0d count", k), 32'(s_cnt), 16);
         check($sformatf("rw%0d rd_data", k), 32'(s_rdd), 32'(e));
         check($sformatf("rw%0d rd_valid", k), 32'(s_rv), 1);
         check($sformatf("rw%0d overflow", k), 32'(s_ovf), 0);
      end
      step_std(1, 0, 8'h00, 0);
      check("flush2 count", 32'(s_cnt), 0);

      // Empty FIFO with simultaneous read and write: no bypass.
      step_std(0, 1, 8'hA5, 1);
      check("empty_rw underflow", 32'(s_unf), 1);
      check("empty_rw count", 32'(s_cnt), 1);
      check("empty_rw rd_valid", 32'(s_rv), 0);
      step_std(0, 0, 8'h00, 1);
      check("empty_rw pop data", 32'(s_rdd), 32'h A5);
      check("empty_rw pop valid", 32'(s_rv), 1);
      check("empty_rw pop empty", 32'(s_empty), 1);

      // FWFT head visibility and pop.
      step_fwft(0, 1, 8'h3C, 0);
      check("fwft head data", 32'(f_rdd), 32'h3C);
      check("fwft head empty", 32'(f_empty), 0);
      check("fwft head rd_valid", 32'(f_rv), 1);
      step_fwft(0, 1, 8'h3D, 1);
      check("fwft rw data", 32'(f_rdd), 32'h3D);
      check("fwft rw count", 32'(f_cnt), 1);
      step_fwft(0, 0, 8'h00, 1);
      check("fwft pop empty", 32'(f_empty), 1);
      check("fwft pop rd_valid", 32'(f_rv), 0);

      // Flush together with a write, with underflow set beforehand.
      for (int i = 0; i < 5; i++) step_std(0, 1, 8'(8'h70 + i), 0);
      check("pre_flush count", 32'(s_cnt), 5);
      step_std(1, 1, 8'h99, 0);
      check("flush_wr count", 32'(s_cnt), 0);
      check("flush_wr empty", 32'(s_empty), 1);
      check("flush_wr flags", {30'd0, s_ovf, s_unf}, 0);
      check("flush_wr rd_valid", 32'(s_rv), 0);

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 3; i++) step_std(0, 1, 8'(8'h80 + i), 0);
      step_std(0, 1, 8'h83, 1);
      @(negedge clk);
      s_wr = 1; s_wd = 8'h84;
      #2;
      rst_n = 1'b0;
      #1;
      check("async count", 32'(s_cnt), 0);
      check("async empty", 32'(s_empty), 1);
      check("async almost_empty", 32'(s_ae), 1);
      check("async rd_valid", 32'(s_rv), 0);
      check("async rd_data", 32'(s_rdd), 0);
      s_wr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step_std(0, 0, 8'h00, 0);
      check("post_reset count", 32'(s_cnt), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO that replaces the fixed 16x8 buffer in the RS-232 TX/RX datapaths. It adds full detection, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow flags. It also offers a selectable first-word-fall-through (FWFT) read mode, so the UART transmitter can see the head byte without a read bubble.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

Ports (CW = $clog2(DEPTH)+1):
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous clear of contents and error flags
- wr_en  in  1  write request
- wr_data  in  WIDTH  write word
- rd_en  in  1  read (pop) request
- rd_data  out  WIDTH  read word
- rd_valid  out  1  standard mode: rd_data updated this cycle; FWFT: equals !empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Reset values: pointers 0, count 0, rd_data 0, rd_valid 0 (FWFT: 0), empty 1, full 0, almost_empty 1, almost_full 0 (unless AF_LEVEL==0, illegal), overflow 0, underflow 0.
- Pointers are CW bits wide; the low bits address storage; wrap is modulo 2·DEPTH. Full and empty also come from count, and the two derivations must agree.
- Read accept: rd_acc = rd_en && !empty. Write accept: wr_acc = wr_en && (!full || rd_acc).
- Full with simultaneous rd_en and wr_en: both are accepted, count is unchanged, and the popped word is the old head.
- Empty with simultaneous rd_en and wr_en: the write is accepted, the read is rejected, and underflow is set. There is no bypass.
- count next = count + wr_acc − rd_acc.
- wr_en && !wr_acc sets overflow. rd_en && !rd_acc sets underflow. Both flags hold until flush or reset.
- Standard mode (FWFT=0): on rd_acc, rd_data <= mem[rptr] and rd_valid pulses for 1 cycle. Otherwise rd_data holds its value and rd_valid is 0.
- FWFT mode: rd_data = mem[rptr] combinationally. It is defined only while !empty. rd_en pops the head shown.
- flush: pointers and count go to 0, overflow/underflow are cleared, and rd_valid goes to 0. flush has priority over wr_en/rd_en in the same cycle. Storage contents are not cleared.
- Async reset mid-transfer: all state returns to reset values immediately. An in-flight write is lost.

## Timing
- Flags and count are registered state or pure decodes of registered count. They change only after the clock edge that accepted the transfer.
- Standard read latency: rd_data is valid 1 cycle after the rd_en edge, qualified by rd_valid.
- FWFT: the first word written to an empty FIFO appears on rd_data, with empty deasserted, in the cycle after the write edge.
- Write-to-read throughput: 1 word/cycle sustained in both modes. Simultaneous read and write at any fill level is legal.
- No combinational path from wr_en/rd_en to any output except none. FWFT rd_data depends only on rptr and storage.

## Structure
- Shared package fifo_pkg: constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1, plus a clog2-based width helper reused by the UART blocks.
- Sub-module fifo_mem: a DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port.
- sync_fifo owns the pointers, count, flags and output register. It contains no storage.

## Test plan
- Reset, then write 0x11..0x1F (15 words, DEPTH=16, AF_LEVEL=14): count=15, almost_full=1, full=0. One more write gives full=1. A 17th write is rejected: overflow=1, count=16.
- Fill, then drain 16 reads in standard mode: rd_data = 0x11.., each word one cycle after its rd_en with rd_valid=1. Then empty=1. A 17th read sets underflow=1 and rd_valid stays 0.
- Full FIFO with simultaneous wr_en/rd_en for 20 cycles: count stays 16, no overflow, and output order is preserved across pointer wrap.
- Empty FIFO with simultaneous wr_en (0xA5) and rd_en: underflow=1, count=1, and the next read returns 0xA5.
- FWFT=1: write 0x3C to an empty FIFO. The next cycle shows rd_data=0x3C, empty=0, rd_valid=1. Pop it: empty=1.
- Write 5 words, then assert flush together with wr_en: count=0, empty=1, overflow/underflow=0. Drop rst_n asynchronously mid-stream: all outputs take reset values before the next clk edge.
